// File: rtl/tt_trng_harvester.sv
// Ring-oscillator entropy harvester: sync, XOR-combine, optional von Neumann / LFSR whitening, word packing.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module tt_trng_harvester #(
  parameter int                N_SRC     = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h0001,
  parameter int                WORD_W    = 8,
  parameter int                REP_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [N_SRC-1:0]  ent_in,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              overrun,
  output logic              health_fail
);

  localparam int                CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [N_SRC-1:0]  r_sync1;
  logic [N_SRC-1:0]  r_sync2;
  logic              r_raw;
  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_count;
  logic [WORD_W-1:0] r_acc;
  logic              r_vn_phase;
  logic              r_vn_first;
  logic [LFSR_W-1:0] r_lfsr;
  logic              r_rd_valid;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_overrun;

  logic              w_lfsr_bit;
  logic              w_lfsr_fb;
  logic              w_vn_pair;
  logic              w_bit_vld;
  logic              w_bit;
  logic              w_read;
  logic              w_room;
  logic              w_load;
  logic              w_health_block;
  logic [WORD_W-1:0] w_acc_next;

  // Two-flop synchroniser per line, then a registered parity of the synchronised taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_raw   <= 1'b0;
    end else begin
      r_sync1 <= ent_in;
      r_sync2 <= r_sync1;
      r_raw   <= ^r_sync2;
    end
  end

  assign w_lfsr_bit = r_lfsr[LFSR_W-1];
  assign w_lfsr_fb  = ^(r_lfsr & LFSR_TAPS);
  assign w_vn_pair  = r_vn_phase && (r_vn_first != r_raw);
  assign w_acc_next = {r_acc[WORD_W-2:0], w_bit};

  always_comb begin
    w_bit_vld = 1'b0;
    w_bit     = 1'b0;
    case (r_mode)
      2'b00: begin
        w_bit_vld = 1'b1;
        w_bit     = r_raw;
      end
      2'b01: begin
        w_bit_vld = w_vn_pair;
        w_bit     = r_vn_first;
      end
      2'b10: begin
        w_bit_vld = w_vn_pair;
        w_bit     = r_vn_first ^ w_lfsr_bit;
      end
      default: begin
        w_bit_vld = 1'b1;
        w_bit     = w_lfsr_bit;
      end
    endcase
  end

  assign w_read = r_rd_valid && rd_ready;
  assign w_room = !r_rd_valid || w_read;
  assign w_load = (r_state == S_FULL) && enable && w_room && !w_health_block;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'b00;
      r_count    <= '0;
      r_acc      <= '0;
      r_vn_phase <= 1'b0;
      r_vn_first <= 1'b0;
      r_lfsr     <= SEED_EFF;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        r_lfsr     <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
        r_vn_phase <= !r_vn_phase;
        if (!r_vn_phase) r_vn_first <= r_raw;
      end
      case (r_state)
        S_IDLE: begin
          r_count    <= '0;
          r_vn_phase <= 1'b0;
          r_mode     <= mode;
          if (enable) begin
            r_state   <= S_COLLECT;
            r_overrun <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (!enable) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_vn_phase <= 1'b0;
          end else if (w_bit_vld) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CNT_W'(1);
            if (r_count == CNT_LAST) r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (!enable) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_vn_phase <= 1'b0;
          end else if (w_load) begin
            // The bit arriving in the hand-off cycle starts the next word
            r_state <= S_COLLECT;
            r_acc   <= w_bit_vld ? w_acc_next : r_acc;
            r_count <= w_bit_vld ? CNT_W'(1) : '0;
          end else if (!w_room) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_load) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= r_acc;
    end else if (w_read) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign overrun  = r_overrun;

`ifdef TRNG_HEALTH_EN
  localparam int               REP_W   = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_prev;
  logic             r_health_fail;
  logic [REP_W-1:0] w_rep_next;

  always_comb begin
    w_rep_next = r_rep_cnt;
    if (r_rep_cnt == '0 || r_raw != r_rep_prev) w_rep_next = REP_W'(1);
    else if (r_rep_cnt < REP_MAX)               w_rep_next = r_rep_cnt + REP_W'(1);
  end

  // The LFSR-only test mode carries no entropy, so it is kept out of the run-length check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt     <= '0;
      r_rep_prev    <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (r_state == S_IDLE || r_mode == 2'b11) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt  <= w_rep_next;
      r_rep_prev <= r_raw;
      if (w_rep_next == REP_MAX) r_health_fail <= 1'b1;
    end
  end

  assign w_health_block = r_health_fail;
  assign health_fail    = r_health_fail;
`else
  assign w_health_block = 1'b0;
  assign health_fail    = 1'b0;
`endif

endmodule

// File: tb/tb_tt_trng_harvester.sv
// Bench for tt_trng_harvester: directed scenarios plus randomized traffic against a bit-stream reference model.
module tb_tt_trng_harvester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] ent_in = 4'b0000;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       overrun;
  logic       health_fail;

  int n_vec = 0;
  int n_bad = 0;
  int n_words = 0;

  tt_trng_harvester dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .ent_in(ent_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .overrun(overrun), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a stream of candidate bits chopped into 8-bit words,
  // one completed word waiting for space, and one word held for the reader.
  logic [2:0]  m_hist;
  logic        m_act;
  logic [1:0]  m_mode;
  logic [15:0] m_lf;
  int          m_first;
  int          m_nb;
  logic [7:0]  m_word;
  logic        m_ready;
  logic        m_held;
  logic [7:0]  m_hword;
  logic        m_ovr;
  int          m_rep;
  logic        m_prev;
  logic        m_hf;

  always @(posedge clk or negedge rst_n) begin
    logic raw, lb, has, b, rd, ld, hf_n;
    if (!rst_n) begin
      m_hist = 3'b000; m_act = 1'b0; m_mode = 2'b00; m_lf = 16'h0001;
      m_first = -1; m_nb = 0; m_word = 8'h00; m_ready = 1'b0;
      m_held = 1'b0; m_hword = 8'h00; m_ovr = 1'b0;
      m_rep = 0; m_prev = 1'b0; m_hf = 1'b0;
    end else begin
      raw  = m_hist[2];
      m_hist = {m_hist[1:0], ^ent_in};
      rd   = m_held && rd_ready;
      ld   = 1'b0;
      hf_n = m_hf;
`ifdef TRNG_HEALTH_EN
      if (!m_act || m_mode == 2'b11) m_rep = 0;
      else begin
        if (m_rep == 0 || raw != m_prev) m_rep = 1;
        else if (m_rep < 32) m_rep++;
        m_prev = raw;
        if (m_rep == 32) hf_n = 1'b1;
      end
`endif
      if (!m_act) begin
        m_mode = mode;
        if (enable) begin
          m_act = 1'b1; m_ovr = 1'b0; m_first = -1; m_nb = 0; m_word = 8'h00; m_ready = 1'b0;
        end
      end else begin
        lb = m_lf[15];
        has = 1'b0;
        b = 1'b0;
        if (m_mode == 2'b00) begin has = 1'b1; b = raw; end
        else if (m_mode == 2'b11) begin has = 1'b1; b = lb; end
        else if (m_first < 0) m_first = int'(raw);
        else begin
          if (m_first != int'(raw)) begin
            has = 1'b1;
            b = (m_first == 1) ^ ((m_mode == 2'b10) ? lb : 1'b0);
          end
          m_first = -1;
        end
        m_lf = {m_lf[14:0], ^(m_lf & 16'hB400)};
        if (!enable) begin
          m_act = 1'b0; m_nb = 0; m_word = 8'h00; m_ready = 1'b0; m_first = -1;
        end else if (m_ready) begin
          if ((!m_held || rd) && !m_hf) begin
            ld = 1'b1; m_hword = m_word; m_ready = 1'b0; m_nb = 0; m_word = 8'h00;
            if (has) begin m_word = {m_word[6:0], b}; m_nb++; end
          end else if (!(!m_held || rd)) begin
            m_ovr = 1'b1;
          end
        end else if (has) begin
          m_word = {m_word[6:0], b};
          m_nb++;
          if (m_nb == 8) m_ready = 1'b1;
        end
      end
      m_hf = hf_n;
      m_held = ld ? 1'b1 : (rd ? 1'b0 : m_held);
      if (ld) n_words++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("rd_valid", rd_valid, m_held);
      if (m_held) check_eq("rd_data", rd_data, m_hword);
      check_eq("overrun", overrun, m_ovr);
      check_eq("health_fail", health_fail, m_hf);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_word(input string tag, output logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!rd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, rd_valid, 1'b1);
    d = rd_data;
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0;
    #1;
    check_eq("reset_rd_valid", rd_valid, 1'b0);
    check_eq("reset_rd_data", rd_data, 8'h00);
    check_eq("reset_overrun", overrun, 1'b0);
    check_eq("reset_health", health_fail, 1'b0);

    // LFSR-only words, first word timing
    mode = 2'b11; rd_ready = 1'b1;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check_eq("t1_no_valid_early", rd_valid, 1'b0);
    end
    @(negedge clk);
    check_eq("t1_first_valid", rd_valid, 1'b1);
    check_eq("t1_word0", rd_data, 8'h00);
    repeat (8) @(negedge clk);
    check_eq("t1_second_valid", rd_valid, 1'b1);
    check_eq("t1_word1", rd_data, 8'h01);

    // Raw XOR with constant parity
    mode = 2'b00; ent_in = 4'b0001;
    do_reset();
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_word("t2_ones_a_valid", w);
    check_eq("t2_ones_a", w, 8'hFF);
    wait_word("t2_ones_b_valid", w);
    check_eq("t2_ones_b", w, 8'hFF);
    enable = 1'b0; ent_in = 4'b0011;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_word("t2_zeros_a_valid", w);
    check_eq("t2_zeros_a", w, 8'h00);
    wait_word("t2_zeros_b_valid", w);
    check_eq("t2_zeros_b", w, 8'h00);

    // Von Neumann on constant input never emits
    mode = 2'b01; ent_in = 4'b0101;
    do_reset();
    enable = 1'b1;
    repeat (64) @(negedge clk);
    check_eq("t3_vn_no_word", rd_valid, 1'b0);

    // Back-pressure, overrun and recovery
    mode = 2'b11; rd_ready = 1'b0;
    do_reset();
    enable = 1'b1;
    repeat (28) @(negedge clk);
    check_eq("t4_held_valid", rd_valid, 1'b1);
    check_eq("t4_held_word", rd_data, 8'h00);
    check_eq("t4_overrun_set", overrun, 1'b1);
    rd_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_next_word", rd_data, 8'h01);
    repeat (3) @(negedge clk);
    check_eq("t4_overrun_sticky", overrun, 1'b1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t4_overrun_idle", overrun, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    check_eq("t4_overrun_cleared", overrun, 1'b0);

    // Partial word discarded, then reset while stalled in FULL
    mode = 2'b11; rd_ready = 1'b1;
    do_reset();
    enable = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check_eq("t5_fresh_no_valid", rd_valid, 1'b0);
    end
    @(negedge clk);
    check_eq("t5_fresh_valid", rd_valid, 1'b1);
    check_eq("t5_fresh_word", rd_data, 8'h00);
    rd_ready = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t5_stalled_overrun", overrun, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_rd_valid", rd_valid, 1'b0);
    check_eq("t5_rst_rd_data", rd_data, 8'h00);
    check_eq("t5_rst_overrun", overrun, 1'b0);
    check_eq("t5_rst_health", health_fail, 1'b0);

    // Repetition-count health alarm
    mode = 2'b00; ent_in = 4'b0111; rd_ready = 1'b1;
    do_reset();
    enable = 1'b1;
    repeat (40) @(negedge clk);
`ifdef TRNG_HEALTH_EN
    check_eq("t6_health_set", health_fail, 1'b1);
    begin
      int seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (rd_valid) seen++;
      end
      check_eq("t6_no_more_words", seen, 0);
    end
`else
    check_eq("t6_health_off", health_fail, 1'b0);
    wait_word("t6_words_continue", w);
    check_eq("t6_word_ones", w, 8'hFF);
`endif

    // Randomized traffic
    do_reset();
    n_words = 0;
    for (int c = 0; c < 3000; c++) begin
      ent_in   = 4'($urandom);
      rd_ready = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom);
      if ($urandom_range(0, 39) == 0) enable = !enable;
      else if (c == 0) enable = 1'b1;
      @(negedge clk);
    end
    check_eq("rand_words_flowed", (n_words > 20), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
